// File: rtl/conv_cfg_pkg.sv
// conv_cfg_pkg: shared types and defaults for the convolution coefficient controller
package conv_cfg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PENDING, COMMIT} cfg_state_t;
  localparam int NUM_COEF_DEF = 25;
  localparam int COEF_W_DEF = 16;
  typedef logic signed [COEF_W_DEF-1:0] coef_t;
endpackage

// File: rtl/coef_bank.sv
// coef_bank: coefficient register array with indexed write, bulk load and registered read
module coef_bank #(
  parameter int N = 25,
  parameter int W = 16,
  parameter logic [W-1:0] RESET_CENTER = 'h0100,
  localparam int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic signed [W-1:0] wdata,
  input  logic                load,
  input  logic signed [W-1:0] load_data [N],
  input  logic [AW-1:0]       raddr,
  output logic signed [W-1:0] rdata,
  output logic signed [W-1:0] q [N]
);
  logic signed [W-1:0] mem_q [N];
  logic signed [W-1:0] mem_d [N];
  logic signed [W-1:0] rdata_q, rdata_d;
  // bulk load replaces every word at once; otherwise at most one word is written
  always_comb begin
    for (int i = 0; i < N; i++) mem_d[i] = load ? load_data[i] : (we && waddr == AW'(i)) ? wdata : mem_q[i];
    rdata_d = (int'(raddr) < N) ? mem_q[raddr] : '0;
  end
  // storage and read register; reset yields the identity kernel
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= (i == N / 2) ? RESET_CENTER : '0;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end
  assign q     = mem_q;
  assign rdata = rdata_q;
endmodule

// File: rtl/conv_coef_ctrl.sv
// conv_coef_ctrl: loads kernel coefficients into a shadow bank and commits them on frame start
module conv_coef_ctrl
  import conv_cfg_pkg::*;
#(
  parameter int NUM_COEF = NUM_COEF_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter logic [COEF_W-1:0] RESET_CENTER = 'h0100,
  localparam int AW = $clog2(NUM_COEF),
  localparam int CW = $clog2(NUM_COEF + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vs_i,
  input  logic                     cfg_start,
  input  logic                     cfg_write,
  input  logic signed [COEF_W-1:0] cfg_data,
  input  logic [AW-1:0]            rd_addr,
  output logic signed [COEF_W-1:0] rd_data,
  output logic signed [COEF_W-1:0] coef_o [NUM_COEF],
  output logic                     busy_o,
  output logic [CW-1:0]            wr_cnt_o,
  output logic                     coef_updated_o,
  output logic                     cfg_err_o
);
  cfg_state_t state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic vs_q, busy_q, busy_d, upd_q, upd_d, err_q, err_d, wr_en, commit;
  logic vs_rise;
  logic signed [COEF_W-1:0] shadow_q [NUM_COEF];
  logic signed [COEF_W-1:0] shadow_rd_unused;
  assign vs_rise = vs_i & ~vs_q;
  // next state, write/commit strobes and error tracking
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d  = cfg_start ? LOAD : IDLE;
        wr_cnt_d = '0;
        err_d    = err_q | (cfg_write & ~cfg_start);
      end
      LOAD: begin
        wr_en    = cfg_write & ~cfg_start;
        wr_cnt_d = cfg_start ? '0 : wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
        state_d  = (wr_en && wr_cnt_q == CW'(NUM_COEF - 1)) ? PENDING : LOAD;
      end
      PENDING: begin
        state_d  = cfg_start ? LOAD : vs_rise ? COMMIT : PENDING;
        wr_cnt_d = cfg_start ? '0 : wr_cnt_q;
        err_d    = err_q | (cfg_write & ~cfg_start);
      end
      default: begin
        commit   = 1'b1;
        state_d  = IDLE;
        wr_cnt_d = '0;
        err_d    = err_q | cfg_write | cfg_start;
      end
    endcase
    busy_d = state_d != IDLE;
    upd_d  = commit;
  end
  // control registers; the update pulse lands with the freshly loaded active bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      vs_q     <= 1'b0;
      busy_q   <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      vs_q     <= vs_i;
      busy_q   <= busy_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end
  coef_bank #(.N(NUM_COEF), .W(COEF_W), .RESET_CENTER(RESET_CENTER)) u_shadow (
    .clk(clk), .rst(rst), .we(wr_en), .waddr(AW'(wr_cnt_q)), .wdata(cfg_data),
    .load(1'b0), .load_data(coef_o), .raddr('0), .rdata(shadow_rd_unused), .q(shadow_q)
  );
  coef_bank #(.N(NUM_COEF), .W(COEF_W), .RESET_CENTER(RESET_CENTER)) u_active (
    .clk(clk), .rst(rst), .we(1'b0), .waddr('0), .wdata('0),
    .load(commit), .load_data(shadow_q), .raddr(rd_addr), .rdata(rd_data), .q(coef_o)
  );
  assign busy_o         = busy_q;
  assign wr_cnt_o       = wr_cnt_q;
  assign coef_updated_o = upd_q;
  assign cfg_err_o      = err_q;
endmodule

// File: tb/tb_conv_coef_ctrl.sv
// tb_conv_coef_ctrl: directed and random stimulus checked against a behavioural model
module tb_conv_coef_ctrl;
  import conv_cfg_pkg::*;
  localparam int N = 25;
  localparam int P_IDLE = 0, P_FILL = 1, P_WAIT = 2, P_COPY = 3;
  logic clk = 1'b0, rst, vs_i, cfg_start, cfg_write, busy_o, coef_updated_o, cfg_err_o;
  logic [15:0] cfg_data;
  logic [4:0] rd_addr, wr_cnt_o;
  coef_t rd_data;
  coef_t coef_o [N];
  int checks = 0, failures = 0, upd_count = 0;
  logic [15:0] m_act [N], m_shd [N], m_rd;
  int m_ph, m_cnt;
  bit m_err, m_vs, m_upd, v;
  always #5 clk = ~clk;
  conv_coef_ctrl dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .cfg_start(cfg_start), .cfg_write(cfg_write),
    .cfg_data(cfg_data), .rd_addr(rd_addr), .rd_data(rd_data), .coef_o(coef_o),
    .busy_o(busy_o), .wr_cnt_o(wr_cnt_o), .coef_updated_o(coef_updated_o), .cfg_err_o(cfg_err_o)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = (i == N / 2) ? 16'h0100 : 16'h0000;
      m_shd[i] = m_act[i];
    end
    m_ph = P_IDLE; m_cnt = 0; m_err = 0; m_vs = 0; m_upd = 0; m_rd = 16'h0;
  endtask
  function automatic int bank_bad(input logic [15:0] ref_bank [N]);
    for (int i = 0; i < N; i++) if (coef_o[i] !== ref_bank[i]) return i;
    return -1;
  endfunction
  task automatic cyc(input bit s, input bit w, input logic [15:0] d, input bit vs, input logic [4:0] a, input bit r = 0);
    bit rise;
    cfg_start = s; cfg_write = w; cfg_data = d; vs_i = vs; rd_addr = a; rst = r;
    if (r) m_reset();
    else begin
      m_rd = (a < N) ? m_act[a] : 16'h0;
      rise = vs && !m_vs;
      m_vs = vs;
      m_upd = 0;
      case (m_ph)
        P_COPY: begin
          m_act = m_shd; m_upd = 1; m_ph = P_IDLE; m_cnt = 0;
          if (s || w) m_err = 1;
        end
        P_WAIT: begin
          if (s) begin m_ph = P_FILL; m_cnt = 0; end
          else begin
            if (w) m_err = 1;
            if (rise) m_ph = P_COPY;
          end
        end
        P_FILL: begin
          if (s) m_cnt = 0;
          else if (w) begin
            m_shd[m_cnt] = d; m_cnt++;
            if (m_cnt == N) m_ph = P_WAIT;
          end
        end
        default: begin
          if (s) begin m_ph = P_FILL; m_cnt = 0; end
          else if (w) m_err = 1;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (coef_updated_o === 1'b1) upd_count++;
    chk("coef_bank_bad_index", 16'(bank_bad(m_act)), 16'hFFFF);
    chk("busy", {15'h0, busy_o}, {15'h0, m_ph != P_IDLE});
    chk("wr_cnt", {11'h0, wr_cnt_o}, 16'(m_cnt));
    chk("coef_updated", {15'h0, coef_updated_o}, {15'h0, m_upd});
    chk("cfg_err", {15'h0, cfg_err_o}, {15'h0, m_err});
    chk("rd_data", rd_data, m_rd);
  endtask
  task automatic idle(input int n, input bit vs);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, vs, 5'd0);
  endtask
  task automatic commit_frame();
    idle(2, 0);
    idle(1, 1);
    idle(1, 1);
    idle(2, 0);
  endtask
  initial begin
    logic [15:0] exp_bank [N];
    m_reset();
    cyc(0, 0, 16'h0, 0, 5'd0, 1);
    cyc(0, 0, 16'h0, 0, 5'd0, 1);
    chk("t1_busy", {15'h0, busy_o}, 16'h0);
    chk("t1_center", coef_o[12], 16'h0100);
    chk("t1_side", coef_o[0], 16'h0000);
    cyc(0, 0, 16'h0, 0, 5'd12);
    chk("t1_rd_center", rd_data, 16'h0100);
    upd_count = 0;
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int i = 0; i < N; i++) cyc(0, 1, 16'(i + 1), 0, 5'd0);
    chk("t2_pending_busy", {15'h0, busy_o}, 16'h1);
    chk("t2_cnt_full", {11'h0, wr_cnt_o}, 16'd25);
    chk("t2_active_held", coef_o[0], 16'h0000);
    commit_frame();
    for (int i = 0; i < N; i++) exp_bank[i] = 16'(i + 1);
    chk("t2_bank_ramp", 16'(bank_bad(exp_bank)), 16'hFFFF);
    chk("t2_update_once", 16'(upd_count), 16'd1);
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 16'($urandom), 0, 5'd0);
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int i = 0; i < N; i++) cyc(0, 1, 16'hFFFF, 0, 5'd0);
    chk("t3_cnt_full", {11'h0, wr_cnt_o}, 16'd25);
    commit_frame();
    for (int i = 0; i < N; i++) exp_bank[i] = 16'hFFFF;
    chk("t3_bank_ones", 16'(bank_bad(exp_bank)), 16'hFFFF);
    chk("t3_no_err", {15'h0, cfg_err_o}, 16'h0);
    upd_count = 0;
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int i = 0; i < N - 1; i++) cyc(0, 1, 16'h0A00 + 16'(i), 0, 5'd0);
    cyc(0, 1, 16'h0A18, 1, 5'd0);
    idle(3, 1);
    chk("t4_still_pending", {15'h0, busy_o}, 16'h1);
    chk("t4_no_update", 16'(upd_count), 16'd0);
    chk("t4_bank_held", 16'(bank_bad(exp_bank)), 16'hFFFF);
    commit_frame();
    for (int i = 0; i < N; i++) exp_bank[i] = 16'h0A00 + 16'(i);
    chk("t4_bank_next_frame", 16'(bank_bad(exp_bank)), 16'hFFFF);
    chk("t4_update_once", 16'(upd_count), 16'd1);
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0077, 0, 5'd0);
    cyc(1, 1, 16'h0099, 0, 5'd0);
    chk("t5_start_wins_cnt", {11'h0, wr_cnt_o}, 16'd0);
    chk("t5_start_wins_err", {15'h0, cfg_err_o}, 16'h0);
    for (int i = 0; i < N; i++) cyc(0, 1, 16'h0055, 0, 5'd0);
    commit_frame();
    cyc(0, 1, 16'h1234, 0, 5'd0);
    idle(3, 0);
    chk("t5_err_sticky", {15'h0, cfg_err_o}, 16'h1);
    for (int i = 0; i < N; i++) exp_bank[i] = 16'h0055;
    chk("t5_bank_after_idle_write", 16'(bank_bad(exp_bank)), 16'hFFFF);
    cyc(1, 0, 16'h0, 0, 5'd0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 16'h0033, 0, 5'd0);
    chk("t6_cnt_seven", {11'h0, wr_cnt_o}, 16'd7);
    cyc(0, 0, 16'h0, 0, 5'd0, 1);
    for (int i = 0; i < N; i++) exp_bank[i] = (i == 12) ? 16'h0100 : 16'h0;
    chk("t6_identity", 16'(bank_bad(exp_bank)), 16'hFFFF);
    chk("t6_busy", {15'h0, busy_o}, 16'h0);
    chk("t6_cnt", {11'h0, wr_cnt_o}, 16'h0);
    v = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 29) == 0) v = !v;
      cyc($urandom_range(0, 199) < 3, $urandom_range(0, 99) < 60, 16'($urandom), v,
          5'($urandom_range(0, 31)), $urandom_range(0, 999) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_coef_ctrl.md
Name: conv_coef_ctrl

Overview:
Configuration controller for the video convolution stages: gray blur and Sobel.
- Accepts a serial stream of 16-bit kernel coefficients into a shadow bank.
- Commits the shadow bank to the active bank atomically on the next frame boundary, so a kernel never changes mid-frame.
- Sits between the host-side coefficient write port and the coef inputs of the convolution instances.
- Provides registered readback of the active bank.

Parameters:
- NUM_COEF, 25: coefficients per kernel (5x5 max kernel).
- COEF_W, 16: coefficient width, signed, 8 fractional bits.
- RESET_CENTER, 16'h0100: reset value of the centre coefficient (index NUM_COEF/2). Gives an identity kernel out of reset.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- vs_i  in  1  vertical sync, already polarity-corrected (active-high)
- cfg_start  in  1  pulse: begin a new coefficient load
- cfg_write  in  1  coefficient write strobe
- cfg_data  in  COEF_W  coefficient value
- rd_addr  in  $clog2(NUM_COEF)  readback index into the active bank
- rd_data  out  COEF_W  active coefficient at rd_addr
- coef_o  out  COEF_W x NUM_COEF (unpacked array)  active bank to the convolution instances
- busy_o  out  1  load or commit outstanding
- wr_cnt_o  out  $clog2(NUM_COEF+1)  words accepted in the current load
- coef_updated_o  out  1  one-cycle pulse: active bank replaced
- cfg_err_o  out  1  sticky: write outside LOAD, or start during commit cycle

Behaviour:
Reset (synchronous, active-high):
- State IDLE, wr_cnt 0, busy_o 0, coef_updated_o 0, cfg_err_o 0, rd_data 0.
- Shadow and active banks all 0, except index NUM_COEF/2 = RESET_CENTER.
- Reset mid-load discards the partial load; the active bank returns to the identity kernel.

vs_i handling:
- vs_i is registered once internally.
- vs_rise = vs_i & ~vs_q.

FSM states: IDLE, LOAD, PENDING, COMMIT.
- IDLE: cfg_start -> LOAD with wr_cnt=0. cfg_write in IDLE sets cfg_err_o; data is dropped.
- LOAD:
  - cfg_write stores cfg_data to shadow[wr_cnt] and increments wr_cnt.
  - The write that makes wr_cnt = NUM_COEF -> PENDING.
  - cfg_start in LOAD restarts: wr_cnt=0, shadow contents kept but overwritten by subsequent writes.
  - cfg_start and cfg_write in the same cycle: start wins, the write is dropped, no error.
- PENDING:
  - Waits for vs_rise, then -> COMMIT.
  - vs_rise is evaluated only while already in PENDING. If the final write coincides with vs_rise, the commit waits for the following frame.
  - cfg_write sets cfg_err_o.
  - cfg_start aborts the pending commit -> LOAD, wr_cnt=0.
- COMMIT (single cycle):
  - active <= shadow (all NUM_COEF words in that one cycle).
  - coef_updated_o = 1 in the cycle after the copy, aligned with the new coef_o.
  - -> IDLE.
  - cfg_start here sets cfg_err_o and is ignored. cfg_write sets cfg_err_o.

Outputs:
- busy_o = 1 in LOAD, PENDING and COMMIT; registered.
- wr_cnt_o is the registered counter. It holds NUM_COEF in PENDING/COMMIT and clears on entry to IDLE.
- rd_data = active[rd_addr], 1-cycle latency. rd_addr >= NUM_COEF returns 0.
- cfg_err_o is cleared only by rst.
- coef_o is driven directly from the active registers.

Arithmetic:
- Data is stored verbatim; no saturation or scaling.
- wr_cnt never wraps, because state leaves LOAD at NUM_COEF.

Decomposition:
- Package conv_cfg_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, PENDING, COMMIT} cfg_state_t
  - localparam NUM_COEF_DEF = 25
  - localparam COEF_W_DEF = 16
  - typedef logic signed [COEF_W_DEF-1:0] coef_t
- One sub-module, coef_bank: a NUM_COEF x COEF_W register array with
  - an indexed write port (shadow use),
  - a bulk-load port (active use),
  - a reset value with RESET_CENTER,
  - a registered read port.
  Instantiated twice: shadow and active.

Test Plan:
1. Reset release, no traffic -> coef_o[12]=16'h0100, all others 0; busy_o=0; rd_addr=12 gives rd_data=16'h0100 one cycle later.
2. cfg_start, then 25 writes of value i+1, then vs_rise -> coef_o[i]=i+1 one cycle after COMMIT. coef_updated_o pulses exactly once. Active bank is unchanged before vs_rise.
3. 10 writes, cfg_start, 25 writes of 16'hFFFF, vs_rise -> all coef_o=16'hFFFF; wr_cnt_o reaches 25; cfg_err_o=0.
4. 25th write in the same cycle as vs_rise -> no commit that frame; commit on the next vs_rise.
5. cfg_write while IDLE (data 16'h1234) -> cfg_err_o=1 and stays 1; active bank unchanged. cfg_start+cfg_write in the same cycle in LOAD -> wr_cnt_o=0, no error.
6. Assert rst during LOAD at wr_cnt=7 after a prior commit of 16'h0055 everywhere -> state IDLE, coef_o back to the identity kernel, busy_o=0, wr_cnt_o=0.
